fastram_ctrl: RTL

FASTRAM_CTRL -- requirements
Module: fastram_ctrl

---
 rtl/fastram_ctrl_if.sv | 40 ++++
 rtl/fastram_ctrl.sv | 105 ++++++++++
 2 files changed

// File: rtl/fastram_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : fastram_ctrl_if
//  Description : 68000-side bus bundle for the Zorro II fast-RAM controller.
//                master = CPU/bus side, slave = RAM controller side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fastram_ctrl_if #(
  parameter int BANKS = 2
);
  logic [2:0]       A;
  logic [2:0]       BASE_RAM;
  logic             RAM_CONFIGURED_n;
  logic [BANKS-1:0] BANK_EN;
  logic             RW_n;
  logic             UDS_n;
  logic             LDS_n;
  logic             AS_n;
  logic             DS_n;
  logic             AS_CPU_n;
  logic             BG_68SEC000_n;
  logic [BANKS-1:0] OE_n;
  logic [BANKS-1:0] WE_ODD_n;
  logic [BANKS-1:0] WE_EVEN_n;
  logic             RAM_ACCESS;
  logic             DTACK_n;

  modport master (
    output A, BASE_RAM, RAM_CONFIGURED_n, BANK_EN, RW_n, UDS_n, LDS_n,
           AS_n, DS_n, AS_CPU_n, BG_68SEC000_n,
    input  OE_n, WE_ODD_n, WE_EVEN_n, RAM_ACCESS, DTACK_n
  );

  modport slave (
    input  A, BASE_RAM, RAM_CONFIGURED_n, BANK_EN, RW_n, UDS_n, LDS_n,
           AS_n, DS_n, AS_CPU_n, BG_68SEC000_n,
    output OE_n, WE_ODD_n, WE_EVEN_n, RAM_ACCESS, DTACK_n
  );
endinterface
`default_nettype wire

// File: rtl/fastram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fastram_ctrl
//  Description : Zorro II fast-RAM controller. Decodes up to four 4MB banks
//                behind the autoconfig base, generates per-bank OE/WE strobes
//                and a DTACK handshake with programmable wait states.
//  Revision    : 1.0 - initial release
// ============================================================================
module fastram_ctrl #(
  parameter int BANKS       = 2,
  parameter int WAIT_STATES = 0
) (
  input  logic          CLKCPU,
  input  logic          RESET_n,
  fastram_ctrl_if.slave bus
);

  // Counter preload; the WAIT state is entered only when WAIT_STATES > 0.
  localparam logic [3:0] C_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic [BANKS-1:0] w_hit;
  logic [BANKS-1:0] w_oe_n;
  logic [BANKS-1:0] w_we_odd_n;
  logic [BANKS-1:0] w_we_even_n;
  logic             w_ram_access;

  // Each bank owns two consecutive 2MB slots above the base, wrapping at 8.
  for (genvar k = 0; k < BANKS; k++) begin : g_bank
    logic [2:0] w_slot_lo;
    logic [2:0] w_slot_hi;

    assign w_slot_lo = bus.BASE_RAM + 3'(2 * k);
    assign w_slot_hi = bus.BASE_RAM + 3'(2 * k + 1);

    assign w_hit[k] = !bus.AS_n && !bus.RAM_CONFIGURED_n && bus.BANK_EN[k] &&
                      ((bus.A == w_slot_lo) || (bus.A == w_slot_hi));

    // Strobes are gated by reset so the RAM is never driven during reset.
    assign w_oe_n[k]      = !(RESET_n && w_hit[k] &&  bus.RW_n && !bus.DS_n);
    assign w_we_odd_n[k]  = !(RESET_n && w_hit[k] && !bus.RW_n && !bus.LDS_n);
    assign w_we_even_n[k] = !(RESET_n && w_hit[k] && !bus.RW_n && !bus.UDS_n);
  end

  assign w_ram_access   = RESET_n && (|w_hit);
  assign bus.RAM_ACCESS = w_ram_access;
  assign bus.OE_n       = w_oe_n;
  assign bus.WE_ODD_n   = w_we_odd_n;
  assign bus.WE_EVEN_n  = w_we_even_n;

  // DTACK follows AS_CPU_n combinationally so it drops without waiting an edge.
  assign bus.DTACK_n = !(RESET_n && (state_q == ST_ACK) && !bus.AS_CPU_n);

  // Handshake sequencer: qualify the cycle, burn wait states, hold acknowledge.
  always_ff @(posedge CLKCPU or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!bus.AS_CPU_n && w_ram_access && bus.BG_68SEC000_n) begin
            if (WAIT_STATES == 0) begin
              state_q <= ST_ACK;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= C_WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (bus.AS_CPU_n) begin
            // Cycle aborted by the CPU before we acknowledged it.
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
          end else if (bus.BG_68SEC000_n) begin
            if (cnt_q == 4'd0) begin
              state_q <= ST_ACK;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
        end
        ST_ACK: begin
          if (bus.AS_CPU_n) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
